// File: rtl/pipelined_generic_decoder_if.sv
// Request/beat bundle for the pipelined decoder.
// Request side: a request transfers when in_valid && in_ready.
// Output side: a beat transfers when out_valid && out_ready; x/x_idx/out_last hold until then.
interface pipelined_generic_decoder_if #(
    parameter int M = 3
);
    localparam int N = 2**M;

    logic         ena;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] sel;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] x;
    logic [M-1:0] x_idx;
    logic         out_last;
    logic         busy;
    logic [1:0]   state;

    modport master (
        output ena, in_valid, sel, mode, out_ready,
        input  in_ready, out_valid, x, x_idx, out_last, busy, state
    );

    modport slave (
        input  ena, in_valid, sel, mode, out_ready,
        output in_ready, out_valid, x, x_idx, out_last, busy, state
    );
endinterface

// File: rtl/pipelined_generic_decoder.sv
// Registered M-to-2**M decoder with one-hot, thermometer, inverted and sweep modes.
// One beat register; the FSM state is exported on bus.state for observation.
module pipelined_generic_decoder #(
    parameter int M = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    pipelined_generic_decoder_if.slave  bus
);
    localparam int N = 2**M;

    localparam logic [1:0] MODE_DECODE = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_INVERT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t       state;
    logic         valid_q;
    logic [N-1:0] x_q;
    logic [M-1:0] idx_q;
    logic [M-1:0] end_q;
    logic         last_q;
    logic         busy_q;

    logic         in_ready;
    logic         accept;
    logic         beat_done;
    logic         scan_start;
    logic [N-1:0] onehot;
    logic [N-1:0] therm;
    logic [N-1:0] load_x;

    // A sweep blocks new requests until its final beat is on the output.
    assign in_ready   = (!valid_q || bus.out_ready) && (!busy_q || last_q);
    assign accept     = bus.in_valid && in_ready;
    assign beat_done  = valid_q && bus.out_ready;
    assign scan_start = (bus.mode == MODE_SCAN) && bus.ena;

    always_comb begin
        onehot = N'(1) << bus.sel;
        therm  = '0;
        for (int i = 0; i < N; i++) begin
            if (i <= int'(bus.sel)) therm[i] = 1'b1;
        end
    end

    always_comb begin
        load_x = '0;
        case (bus.mode)
            MODE_DECODE: load_x = bus.ena ? onehot : '0;
            MODE_THERM:  load_x = bus.ena ? therm  : '0;
            MODE_SCAN:   load_x = bus.ena ? N'(1)  : '0;
            MODE_INVERT: load_x = bus.ena ? ~onehot : '1;
            default:     load_x = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            x_q     <= '0;
            idx_q   <= '0;
            end_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (accept) begin
            // Loading wins over retiring: the held beat handshakes on this same edge.
            valid_q <= 1'b1;
            x_q     <= load_x;
            if (scan_start) begin
                state  <= SCAN;
                idx_q  <= '0;
                end_q  <= bus.sel;
                last_q <= (bus.sel == '0);
                busy_q <= 1'b1;
            end else begin
                state  <= HOLD;
                idx_q  <= bus.sel;
                last_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end else if (beat_done) begin
            if (state == SCAN && !last_q) begin
                x_q    <= x_q << 1;
                idx_q  <= idx_q + M'(1);
                last_q <= ((idx_q + M'(1)) == end_q);
            end else begin
                state   <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.x         = x_q;
    assign bus.x_idx     = idx_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state;
endmodule

// File: tb/tb_pipelined_generic_decoder.sv
// Directed bench for pipelined_generic_decoder (M=3): modes, sweep, backpressure, reset.
module tb_pipelined_generic_decoder;
    localparam int M = 3;

    localparam logic [1:0] MD_DECODE = 2'b00;
    localparam logic [1:0] MD_THERM  = 2'b01;
    localparam logic [1:0] MD_SCAN   = 2'b10;
    localparam logic [1:0] MD_INVERT = 2'b11;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [14:0] obs;
    logic [14:0] expv;

    pipelined_generic_decoder_if #(.M(M)) bus ();

    pipelined_generic_decoder #(.M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out_valid, out_last, busy, in_ready, x_idx, x}
    function automatic logic [14:0] pack(input logic v, input logic l, input logic b,
                                         input logic r, input logic [2:0] idx,
                                         input logic [7:0] xv);
        return {v, l, b, r, idx, xv};
    endfunction

    function automatic logic [14:0] snap();
        return {bus.out_valid, bus.out_last, bus.busy, bus.in_ready, bus.x_idx, bus.x};
    endfunction

    task automatic drive(input logic [1:0] md, input logic [2:0] s, input logic e);
        bus.mode     = md;
        bus.sel      = s;
        bus.ena      = e;
        bus.in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.ena = 1'b0; bus.sel = '0; bus.mode = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        tests_run++; obs = snap(); expv = pack(0, 0, 0, 1, 3'd0, 8'h00);
        if (obs !== expv) begin tests_failed++; $display("FAIL reset_outputs got %h expected %h", obs, expv); end
        tests_run++;
        if (bus.state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d expected 0", bus.state); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_decode();
        bus.out_ready = 1'b1;
        drive(MD_DECODE, 3'd5, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests_run++; obs = snap(); expv = pack(1, 1, 0, 1, 3'd5, 8'h20);
        if (obs !== expv) begin tests_failed++; $display("FAIL decode_sel5 got %h expected %h", obs, expv); end
        @(negedge clk);
        tests_run++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            tests_failed++; $display("FAIL decode_idle got %b expected 00", {bus.out_valid, bus.busy});
        end
    endtask

    task automatic test_modes();
        logic [1:0] md   [6] = '{MD_THERM, MD_INVERT, MD_INVERT, MD_DECODE, MD_THERM, MD_THERM};
        logic [2:0] s    [6] = '{3'd3, 3'd3, 3'd3, 3'd6, 3'd7, 3'd0};
        logic       e    [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] ex   [6] = '{8'h0F, 8'hF7, 8'hFF, 8'h00, 8'hFF, 8'h01};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(md[i], s[i], e[i]);
            @(negedge clk);
            tests_run++; obs = snap(); expv = pack(1, 1, 0, 1, s[i], ex[i]);
            if (obs !== expv) begin tests_failed++; $display("FAIL mode_vec%0d got %h expected %h", i, obs, expv); end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL modes_drain got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_scan();
        logic [7:0] bx;
        bus.out_ready = 1'b1;
        drive(MD_SCAN, 3'd3, 1'b1);
        @(negedge clk);
        drive(MD_DECODE, 3'd7, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bx = 8'h01 << k;
            tests_run++; obs = snap(); expv = pack(1, k == 3, 1, k == 3, 3'(k), bx);
            if (obs !== expv) begin tests_failed++; $display("FAIL scan3_beat%0d got %h expected %h", k, obs, expv); end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        tests_run++; obs = snap(); expv = pack(1, 1, 0, 1, 3'd7, 8'h80);
        if (obs !== expv) begin tests_failed++; $display("FAIL scan_back_to_back got %h expected %h", obs, expv); end
        @(negedge clk);
        drive(MD_SCAN, 3'd0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests_run++; obs = snap(); expv = pack(1, 1, 1, 1, 3'd0, 8'h01);
        if (obs !== expv) begin tests_failed++; $display("FAIL scan_sel0 got %h expected %h", obs, expv); end
        @(negedge clk);
        tests_run++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            tests_failed++; $display("FAIL scan_sel0_end got %b expected 00", {bus.out_valid, bus.busy});
        end
        drive(MD_SCAN, 3'd5, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests_run++; obs = snap(); expv = pack(1, 1, 0, 1, 3'd5, 8'h00);
        if (obs !== expv) begin tests_failed++; $display("FAIL scan_ena0 got %h expected %h", obs, expv); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [2:0] noise [3] = '{3'd7, 3'd1, 3'd4};
        bus.out_ready = 1'b0;
        drive(MD_DECODE, 3'd2, 1'b1);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            drive((c == 1) ? MD_INVERT : MD_DECODE, noise[c], 1'b1);
            tests_run++; obs = snap(); expv = pack(1, 1, 0, 0, 3'd2, 8'h04);
            if (obs !== expv) begin tests_failed++; $display("FAIL bp_hold%0d got %h expected %h", c, obs, expv); end
            @(negedge clk);
        end
        drive(MD_DECODE, 3'd6, 1'b1);
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready got %b expected 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests_run++; obs = snap(); expv = pack(1, 1, 0, 1, 3'd6, 8'h40);
        if (obs !== expv) begin tests_failed++; $display("FAIL bp_next got %h expected %h", obs, expv); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] bx;
        bus.out_ready = 1'b1;
        drive(MD_SCAN, 3'd7, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bx = 8'h01 << k;
            tests_run++; obs = snap(); expv = pack(1, 0, 1, 0, 3'(k), bx);
            if (obs !== expv) begin tests_failed++; $display("FAIL rs_beat%0d got %h expected %h", k, obs, expv); end
            if (k < 3) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++; obs = snap(); expv = pack(0, 0, 0, 1, 3'd0, 8'h00);
        if (obs !== expv) begin tests_failed++; $display("FAIL rs_async got %h expected %h", obs, expv); end
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.out_valid, bus.busy} !== 2'b00) begin
                tests_failed++; $display("FAIL rs_quiet%0d got %b expected 00", c, {bus.out_valid, bus.busy});
            end
        end
        drive(MD_DECODE, 3'd1, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests_run++; obs = snap(); expv = pack(1, 1, 0, 1, 3'd1, 8'h02);
        if (obs !== expv) begin tests_failed++; $display("FAIL rs_after got %h expected %h", obs, expv); end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        logic [7:0] bx;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                bx = 8'h01 << (i - 1);
                tests_run++; obs = snap(); expv = pack(1, 1, 0, 1, 3'(i - 1), bx);
                if (obs !== expv) begin tests_failed++; $display("FAIL stream%0d got %h expected %h", i - 1, obs, expv); end
            end
            if (i < 8) drive(MD_DECODE, 3'(i), 1'b1);
            else bus.in_valid = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_end got %b expected 0", bus.out_valid); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_decode();
        test_modes();
        test_scan();
        test_backpressure();
        test_reset_mid_scan();
        test_streaming();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
